lcd_bus_reader: RTL and testbench

Read-cycle engine for the 8-bit HD44780-style LCD bus. It generates correctly timed RS/RW/E read cycles, samples the byte the panel drives, and returns it to the requester. In busy-poll mode it repeats status reads until the busy flag clears. It sits as an additional bus master beside the init sequencer and the button-driven writer. Its bus outputs are muxed onto the panel pins, and its `bus_active` tells the top level to tristate the FPGA data pins and select this master.

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_phase_timer.sv | 27 ++
 rtl/lcd_bus_reader.sv | 162 ++++++++++++++++
 tb/tb_lcd_bus_reader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus masters.
package lcd_pkg;

  // Read engine phases
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EHIGH = 2'd2,
    ST_HOLD  = 2'd3
  } lcd_rd_state_e;

  // Busy flag position in a status read
  localparam int unsigned LCD_BF_BIT = 7;

  // Default bus timing at 50 MHz, shared by all LCD bus masters
  localparam int unsigned LCD_T_AS_CYC = 3;
  localparam int unsigned LCD_T_EH_CYC = 12;
  localparam int unsigned LCD_T_EL_CYC = 13;
  localparam int unsigned LCD_POLL_MAX = 4095;

  function automatic int unsigned lcd_max3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter timing one bus phase; done while the count is zero.
module lcd_phase_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load a new phase length or count down to zero and stop
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Read-cycle engine for the 8-bit LCD bus: timed RS/RW/E read cycles with
// optional busy-flag polling.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int unsigned T_AS_CYC = LCD_T_AS_CYC,
  parameter int unsigned T_EH_CYC = LCD_T_EH_CYC,
  parameter int unsigned T_EL_CYC = LCD_T_EL_CYC,
  parameter int unsigned POLL_MAX = LCD_POLL_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic       rd_poll,
  output logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic [6:0] addr_cnt,
  output logic       rd_timeout,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       bus_active
);

  localparam int unsigned PW = $clog2(lcd_max3(T_AS_CYC, T_EH_CYC, T_EL_CYC)) + 1;
  localparam int unsigned CW = $clog2(POLL_MAX + 1);

  localparam logic [PW-1:0] AS_LD     = PW'(T_AS_CYC - 1);
  localparam logic [PW-1:0] EH_LD     = PW'(T_EH_CYC - 1);
  localparam logic [PW-1:0] EL_LD     = PW'(T_EL_CYC - 1);
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_MAX - 1);

  lcd_rd_state_e state;
  logic          lat_rs;
  logic          lat_poll;
  logic [CW-1:0] poll_cnt;
  logic          tmr_load;
  logic [PW-1:0] tmr_val;
  logic          tmr_done;
  logic          poll_more;

  lcd_phase_timer #(
    .W(PW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Another status read is due: busy still set and read budget not spent.
  // rd_data already holds this read's byte by the time HOLD ends.
  assign poll_more = lat_poll && !lat_rs && rd_data[LCD_BF_BIT] &&
                     (poll_cnt < POLL_LAST);

  // Select the phase length to load on each phase transition
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      ST_IDLE: begin
        if (rd_req) begin
          tmr_load = 1'b1;
          tmr_val  = AS_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = EH_LD;
        end
      end
      ST_EHIGH: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = EL_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_done && poll_more) begin
          tmr_load = 1'b1;
          tmr_val  = AS_LD;
        end
      end
      default: ;
    endcase
  end

  // Phase sequencing, bus pin drive and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lat_rs     <= 1'b0;
      lat_poll   <= 1'b0;
      poll_cnt   <= '0;
      rd_ready   <= 1'b1;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      busy_flag  <= 1'b0;
      addr_cnt   <= '0;
      rd_timeout <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_rw     <= 1'b0;
      lcd_e      <= 1'b0;
      bus_active <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rd_req) begin
            state      <= ST_SETUP;
            lat_rs     <= rd_rs;
            lat_poll   <= rd_poll;
            poll_cnt   <= '0;
            rd_ready   <= 1'b0;
            bus_active <= 1'b1;
            lcd_rw     <= 1'b1;
            lcd_rs     <= rd_rs;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            state <= ST_EHIGH;
            lcd_e <= 1'b1;
          end
        end
        ST_EHIGH: begin
          if (tmr_done) begin
            state     <= ST_HOLD;
            lcd_e     <= 1'b0;
            rd_data   <= lcd_data_in;
            busy_flag <= lat_rs ? 1'b0 : lcd_data_in[LCD_BF_BIT];
            addr_cnt  <= lat_rs ? 7'd0 : lcd_data_in[6:0];
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            if (poll_more) begin
              state    <= ST_SETUP;
              poll_cnt <= poll_cnt + 1'b1;
            end else begin
              state      <= ST_IDLE;
              rd_valid   <= 1'b1;
              rd_ready   <= 1'b1;
              bus_active <= 1'b0;
              lcd_rw     <= 1'b0;
              lcd_rs     <= 1'b0;
              rd_timeout <= lat_poll && !lat_rs && rd_data[LCD_BF_BIT];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader (default timing, POLL_MAX=4).
module tb_lcd_bus_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_req;
  logic       rd_rs;
  logic       rd_poll;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       busy_flag;
  logic [6:0] addr_cnt;
  logic       rd_timeout;
  logic [7:0] lcd_data_in;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic       bus_active;

  int n_cmp = 0;
  int n_bad = 0;

  // Panel response per read (index = E pulse number, last entry repeats)
  logic [7:0] rdtab [4];

  // Results of the last do_read
  int         r_vcyc;
  int         r_pulses;
  int         r_ehigh;
  int         r_efirst;
  int         r_elast;
  logic       r_pin_bad;
  logic [3:0] r_c1;
  logic [7:0] r_data;
  logic       r_bf;
  logic [6:0] r_addr;
  logic       r_to;
  logic [2:0] r_vstat;

  lcd_bus_reader #(
    .POLL_MAX(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_req      (rd_req),
    .rd_rs       (rd_rs),
    .rd_poll     (rd_poll),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .busy_flag   (busy_flag),
    .addr_cnt    (addr_cnt),
    .rd_timeout  (rd_timeout),
    .lcd_data_in (lcd_data_in),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_e       (lcd_e),
    .bus_active  (bus_active)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it until rd_valid (or a 400-cycle bound).
  // Cycle k is the cycle after edge k; edge 0 is the accepting edge.
  task automatic do_read(input logic rs, input logic poll, input logic hold_req);
    logic prev_e;
    rd_rs       = rs;
    rd_poll     = poll;
    rd_req      = 1'b1;
    lcd_data_in = rdtab[0];
    step();
    if (!hold_req) rd_req = 1'b0;
    r_vcyc    = -1;
    r_pulses  = 0;
    r_ehigh   = 0;
    r_efirst  = -1;
    r_elast   = -1;
    r_pin_bad = 1'b0;
    prev_e    = 1'b0;
    for (int k = 1; k <= 400 && r_vcyc < 0; k++) begin
      if (k == 1) r_c1 = {lcd_rw, bus_active, rd_ready, lcd_rs};
      if (lcd_e) begin
        if (!prev_e) begin
          lcd_data_in = rdtab[(r_pulses < 4) ? r_pulses : 3];
          r_pulses++;
          if (r_efirst < 0) r_efirst = k;
        end
        r_ehigh++;
        r_elast = k;
        if (lcd_rw !== 1'b1) r_pin_bad = 1'b1;
      end
      if (bus_active && (lcd_rs !== rs || lcd_rw !== 1'b1)) r_pin_bad = 1'b1;
      prev_e = lcd_e;
      if (rd_valid) begin
        r_vcyc  = k;
        r_data  = rd_data;
        r_bf    = busy_flag;
        r_addr  = addr_cnt;
        r_to    = rd_timeout;
        r_vstat = {rd_ready, bus_active, lcd_rw};
      end else begin
        step();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_req = 1'b0; rd_rs = 1'b0; rd_poll = 1'b0; lcd_data_in = 8'h00;
    repeat (3) step();
    n_cmp++;
    if ({lcd_e, lcd_rw, lcd_rs, bus_active, rd_ready, rd_valid, rd_timeout} !== 7'b0000100) begin
      n_bad++;
      $display("FAIL reset_ctrl: got e/rw/rs/act/rdy/val/to=%b want 0000100",
               {lcd_e, lcd_rw, lcd_rs, bus_active, rd_ready, rd_valid, rd_timeout});
    end
    n_cmp++;
    if ({rd_data, busy_flag, addr_cnt} !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0000", {rd_data, busy_flag, addr_cnt});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_status_read();
    rdtab = '{8'h25, 8'h25, 8'h25, 8'h25};
    do_read(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (r_c1 !== 4'b1100) begin
      n_bad++; $display("FAIL status_cycle1: rw/act/rdy/rs=%b want 1100", r_c1);
    end
    n_cmp++;
    if (r_vcyc !== 29) begin
      n_bad++; $display("FAIL status_valid_cycle: got %0d want 29", r_vcyc);
    end
    n_cmp++;
    if (r_efirst !== 4 || r_elast !== 15 || r_ehigh !== 12 || r_pulses !== 1) begin
      n_bad++;
      $display("FAIL status_e_window: first=%0d last=%0d high=%0d pulses=%0d want 4 15 12 1",
               r_efirst, r_elast, r_ehigh, r_pulses);
    end
    n_cmp++;
    if ({r_data, r_bf, r_addr, r_to} !== {8'h25, 1'b0, 7'h25, 1'b0}) begin
      n_bad++;
      $display("FAIL status_result: data=%h bf=%b addr=%h to=%b want 25 0 25 0",
               r_data, r_bf, r_addr, r_to);
    end
    n_cmp++;
    if (r_vstat !== 3'b100 || r_pin_bad !== 1'b0) begin
      n_bad++;
      $display("FAIL status_valid_pins: rdy/act/rw=%b pin_bad=%b want 100 0", r_vstat, r_pin_bad);
    end
    step();
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL status_valid_pulse: rd_valid=%b one cycle later want 0", rd_valid);
    end
  endtask

  task automatic test_status_busy_nopoll();
    rdtab = '{8'h85, 8'h85, 8'h85, 8'h85};
    do_read(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (r_vcyc !== 29 || r_pulses !== 1 || {r_bf, r_addr, r_to} !== {1'b1, 7'h05, 1'b0}) begin
      n_bad++;
      $display("FAIL busy_nopoll: cyc=%0d pulses=%0d bf=%b addr=%h to=%b want 29 1 1 05 0",
               r_vcyc, r_pulses, r_bf, r_addr, r_to);
    end
    step();
  endtask

  task automatic test_poll_clears();
    rdtab = '{8'hA0, 8'hA0, 8'hA0, 8'h10};
    do_read(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (r_pulses !== 4 || r_vcyc !== 113) begin
      n_bad++; $display("FAIL poll_clear_timing: pulses=%0d cyc=%0d want 4 113", r_pulses, r_vcyc);
    end
    n_cmp++;
    if ({r_data, r_bf, r_addr, r_to} !== {8'h10, 1'b0, 7'h10, 1'b0}) begin
      n_bad++;
      $display("FAIL poll_clear_result: data=%h bf=%b addr=%h to=%b want 10 0 10 0",
               r_data, r_bf, r_addr, r_to);
    end
    n_cmp++;
    if (r_pin_bad !== 1'b0) begin
      n_bad++; $display("FAIL poll_clear_pins: pin_bad=%b want 0", r_pin_bad);
    end
    step();
  endtask

  task automatic test_poll_timeout();
    rdtab = '{8'h80, 8'h80, 8'h80, 8'h80};
    do_read(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (r_pulses !== 4 || r_vcyc !== 113) begin
      n_bad++; $display("FAIL poll_timeout_timing: pulses=%0d cyc=%0d want 4 113", r_pulses, r_vcyc);
    end
    n_cmp++;
    if ({r_to, r_bf, r_addr} !== {1'b1, 1'b1, 7'h00}) begin
      n_bad++;
      $display("FAIL poll_timeout_result: to=%b bf=%b addr=%h want 1 1 00", r_to, r_bf, r_addr);
    end
    step();
  endtask

  task automatic test_data_read();
    rdtab = '{8'hC3, 8'hC3, 8'hC3, 8'hC3};
    do_read(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (r_c1 !== 4'b1101) begin
      n_bad++; $display("FAIL data_cycle1: rw/act/rdy/rs=%b want 1101", r_c1);
    end
    n_cmp++;
    if ({r_data, r_bf, r_addr, r_to} !== {8'hC3, 1'b0, 7'h00, 1'b0} || r_vcyc !== 29) begin
      n_bad++;
      $display("FAIL data_result: data=%h bf=%b addr=%h to=%b cyc=%0d want C3 0 00 0 29",
               r_data, r_bf, r_addr, r_to, r_vcyc);
    end
    n_cmp++;
    if (r_pin_bad !== 1'b0) begin
      n_bad++; $display("FAIL data_rs_held: pin_bad=%b want 0", r_pin_bad);
    end
    step();
  endtask

  task automatic test_reset_mid_e();
    logic seen_valid;
    rd_rs = 1'b0; rd_poll = 1'b0; rd_req = 1'b1; lcd_data_in = 8'h33;
    step();
    rd_req = 1'b0;
    repeat (4) step();   // now in cycle 5, E high
    n_cmp++;
    if (lcd_e !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_pre: lcd_e=%b in cycle 5 want 1", lcd_e);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({lcd_e, rd_ready, bus_active, lcd_rw, rd_valid} !== 5'b01000) begin
      n_bad++;
      $display("FAIL rstmid_after: e/rdy/act/rw/val=%b want 01000",
               {lcd_e, rd_ready, bus_active, lcd_rw, rd_valid});
    end
    seen_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rd_valid || lcd_e) seen_valid = 1'b1;
      step();
    end
    n_cmp++;
    if (seen_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_quiet: activity after reset=%b want 0", seen_valid);
    end
    rdtab = '{8'h4A, 8'h4A, 8'h4A, 8'h4A};
    do_read(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (r_vcyc !== 29 || r_data !== 8'h4A || r_addr !== 7'h4A) begin
      n_bad++;
      $display("FAIL rstmid_recover: cyc=%0d data=%h addr=%h want 29 4A 4A", r_vcyc, r_data, r_addr);
    end
    step();
  endtask

  task automatic test_back_to_back();
    rdtab = '{8'h11, 8'h11, 8'h11, 8'h11};
    do_read(1'b0, 1'b0, 1'b1);   // rd_req held through the whole read
    n_cmp++;
    if (r_vcyc !== 29 || r_pulses !== 1 || r_data !== 8'h11) begin
      n_bad++;
      $display("FAIL b2b_first: cyc=%0d pulses=%0d data=%h want 29 1 11", r_vcyc, r_pulses, r_data);
    end
    rdtab = '{8'h22, 8'h22, 8'h22, 8'h22};
    do_read(1'b1, 1'b0, 1'b0);   // accepted on the edge ending the rd_valid cycle
    n_cmp++;
    if (r_c1 !== 4'b1101 || r_vcyc !== 29 || r_data !== 8'h22 || r_addr !== 7'h00) begin
      n_bad++;
      $display("FAIL b2b_second: c1=%b cyc=%0d data=%h addr=%h want 1101 29 22 00",
               r_c1, r_vcyc, r_data, r_addr);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_status_read();
    test_status_busy_nopoll();
    test_poll_clears();
    test_poll_timeout();
    test_data_read();
    test_reset_mid_e();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
